// File: rtl/alu_retire_stage_pkg.sv
// Shared types and constants for the ALU retire stage: branch kinds,
// write-buffer depth and the branch resolution rule.
package alu_retire_stage_pkg;

  typedef enum logic [1:0] {
    kBR_NONE,
    kBR_EQ,
    kBR_NE,
    kBR_Z
  } br_kind_e;

  localparam int WB_DEPTH = 2;

  // Decides whether a conditional branch is taken from the ALU flags.
  function automatic logic branch_taken(input br_kind_e kind,
                                        input logic     zero,
                                        input logic     equal);
    case (kind)
      kBR_EQ:  return equal;
      kBR_NE:  return ~equal;
      kBR_Z:   return zero;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_retire_stage_wb_fifo.sv
// Circular write buffer between the retire stage and the register file.
// The head entry is always presented on dout straight from storage.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 20
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A pop frees a slot in the same cycle, so push is legal when full only
  // if a pop accompanies it.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count < FULL) | do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the storage array is reset on purpose: the head is visible on
      // dout even when empty, and it must read as zero after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= inc_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= inc_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_retire_stage.sv
// Retire stage behind the ALU: resolves branches, keeps architectural
// flags and a retired counter, and buffers register writes in wb_fifo.
module alu_retire_stage
  import alu_retire_stage_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int DW    = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_zero,
  input  logic          alu_equal,
  input  logic [AW-1:0] dest,
  input  logic          we,
  input  logic [1:0]    br_kind,
  input  logic [DW-1:0] br_target,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [DW-1:0] wb_data,
  output logic [AW-1:0] wb_addr,
  output logic          br_taken,
  output logic [DW-1:0] br_pc,
  output logic          flush,
  output logic          flag_z,
  output logic          flag_eq,
  output logic [15:0]   retired
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  br_kind_e          kind;
  logic [CW-1:0]     count;
  logic [AW+DW-1:0]  head;
  logic              accept;
  logic              push;
  logic              pop;
  logic              taken;
  logic              br_taken_q;
  logic [DW-1:0]     br_pc_q;

  assign kind = br_kind_e'(br_kind);

  // Both terms are registered, so in_ready never depends on in_valid or
  // wb_ready within the same cycle.
  assign in_ready = (count < FULL) & ~br_taken_q;
  assign accept   = in_valid & in_ready;
  assign push     = accept & we;
  assign wb_valid = (count != '0);
  assign pop      = wb_valid & wb_ready;
  assign taken    = accept & branch_taken(kind, alu_zero, alu_equal);

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (AW + DW)
  ) u_wb_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     ({dest, alu_out}),
    .dout    (head),
    .count   (count)
  );

  assign {wb_addr, wb_data} = head;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_taken_q <= 1'b0;
      br_pc_q    <= '0;
      flag_z     <= 1'b0;
      flag_eq    <= 1'b0;
      retired    <= '0;
    end else begin
      br_taken_q <= taken;
      if (taken) br_pc_q <= br_target;
      if (accept) begin
        flag_z  <= alu_zero;
        flag_eq <= alu_equal;
        retired <= retired + 16'd1;
      end
    end
  end

  // The flush pulse is the branch pulse itself; the bubble comes from
  // in_ready being held low while it is high.
  assign br_taken = br_taken_q;
  assign flush    = br_taken_q;
  assign br_pc    = br_pc_q;

endmodule

// File: tb/tb_alu_retire_stage.sv
// Self-checking bench for alu_retire_stage: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_alu_retire_stage;
  import alu_retire_stage_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic        alu_equal;
  logic [3:0]  dest;
  logic        we;
  logic [1:0]  br_kind;
  logic [15:0] br_target;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_data;
  logic [3:0]  wb_addr;
  logic        br_taken;
  logic [15:0] br_pc;
  logic        flush;
  logic        flag_z;
  logic        flag_eq;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [19:0] q[$];
  logic        m_z, m_eq, m_br, m_acc;
  logic [15:0] m_pc;
  int          m_ret;

  alu_retire_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_equal(alu_equal),
    .dest(dest), .we(we), .br_kind(br_kind), .br_target(br_target),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_addr(wb_addr), .br_taken(br_taken), .br_pc(br_pc), .flush(flush),
    .flag_z(flag_z), .flag_eq(flag_eq), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic bit ref_taken(input logic [1:0] k, input logic z, input logic e);
    if (k == kBR_EQ) return e;
    if (k == kBR_NE) return !e;
    if (k == kBR_Z)  return z;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_z = 0; m_eq = 0; m_br = 0; m_pc = '0; m_ret = 0; m_acc = 0;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] a,
                       input logic w, input br_kind_e k, input logic [15:0] t,
                       input logic z, input logic e);
    in_valid = v; alu_out = d; dest = a; we = w; br_kind = k;
    br_target = t; alu_zero = z; alu_equal = e;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 4'h0, 1'b0, kBR_NONE, 16'h0, 1'b0, 1'b0);
  endtask

  // Advance one clock; the model decides acceptance from its own state.
  task automatic cycle();
    bit acc, pp, tk;
    acc = in_valid && (q.size() < 2) && !m_br;
    pp  = (q.size() != 0) && wb_ready;
    tk  = acc && ref_taken(br_kind, alu_zero, alu_equal);
    @(posedge clk);
    if (pp) q.delete(0);
    if (acc && we) q.push_back({dest, alu_out});
    if (acc) begin
      m_z = alu_zero; m_eq = alu_equal; m_ret = (m_ret + 1) % 65536;
    end
    m_br  = tk;
    if (tk) m_pc = br_target;
    m_acc = acc;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wb_ready = 1'b0; idle();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    checks++; if (wb_data !== 16'h0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    checks++; if (wb_addr !== 4'h0) begin errors++; $display("FAIL reset_wb_addr: got %h want 0", wb_addr); end
    checks++; if (br_taken !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL reset_branch: got taken=%b flush=%b want 0", br_taken, flush); end
    checks++; if (br_pc !== 16'h0) begin errors++; $display("FAIL reset_br_pc: got %h want 0", br_pc); end
    checks++; if (flag_z !== 1'b0 || flag_eq !== 1'b0) begin errors++; $display("FAIL reset_flags: got z=%b eq=%b want 0", flag_z, flag_eq); end
    checks++; if (retired !== 16'h0) begin errors++; $display("FAIL reset_retired: got %h want 0", retired); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_write();
    drive(1'b1, 16'h1234, 4'd3, 1'b1, kBR_NONE, 16'h0, 1'b0, 1'b0);
    cycle();
    idle();
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL single_wb_valid: got %b want 1", wb_valid); end
    checks++; if (wb_data !== 16'h1234) begin errors++; $display("FAIL single_wb_data: got %h want 1234", wb_data); end
    checks++; if (wb_addr !== 4'd3) begin errors++; $display("FAIL single_wb_addr: got %h want 3", wb_addr); end
    checks++; if (retired !== 16'd1) begin errors++; $display("FAIL single_retired: got %0d want 1", retired); end
    wb_ready = 1'b1;
    cycle();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", wb_valid); end
  endtask

  task automatic test_fill_drain();
    logic [15:0] got[$];
    wb_ready = 1'b0;
    drive(1'b1, 16'd1, 4'd1, 1'b1, kBR_NONE, 16'h0, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'd2, 4'd2, 1'b1, kBR_NONE, 16'h0, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'd3, 4'd3, 1'b1, kBR_NONE, 16'h0, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    cycle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_hold_in_ready: got %b want 0", in_ready); end
    wb_ready = 1'b1;
    for (int i = 0; i < 10 && got.size() < 3; i++) begin
      if (wb_valid && wb_ready) got.push_back(wb_data);
      cycle();
      if (m_acc) in_valid = 1'b0;
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL drain_count: got %0d pops want 3", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== 16'(i + 1)) begin errors++; $display("FAIL drain_order[%0d]: got %0d want %0d", i, got[i], i + 1); end
    end
    idle();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", wb_valid); end
  endtask

  task automatic test_branch_taken();
    wb_ready = 1'b1;
    drive(1'b1, 16'h00AA, 4'd7, 1'b0, kBR_EQ, 16'h0040, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 16'h0077, 4'd5, 1'b1, kBR_NONE, 16'h0, 1'b0, 1'b0);
    checks++; if (br_taken !== 1'b1 || flush !== 1'b1) begin errors++; $display("FAIL br_pulse: got taken=%b flush=%b want 1", br_taken, flush); end
    checks++; if (br_pc !== 16'h0040) begin errors++; $display("FAIL br_pc: got %h want 0040", br_pc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL br_bubble: got in_ready=%b want 0", in_ready); end
    cycle();
    checks++; if (br_taken !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL br_one_cycle: got taken=%b flush=%b want 0", br_taken, flush); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL br_held_not_taken: got wb_valid=%b want 0", wb_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL br_ready_back: got %b want 1", in_ready); end
    cycle();
    idle();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h0077 || wb_addr !== 4'd5) begin errors++; $display("FAIL br_held_accept: got v=%b d=%h a=%h want 1 0077 5", wb_valid, wb_data, wb_addr); end
    checks++; if (retired !== 16'(m_ret)) begin errors++; $display("FAIL br_retired: got %0d want %0d", retired, m_ret); end
    cycle();
  endtask

  task automatic test_branch_not_taken();
    logic [15:0] r0;
    r0 = 16'(m_ret);
    wb_ready = 1'b1;
    drive(1'b1, 16'h0, 4'd0, 1'b0, kBR_NE, 16'h1111, 1'b1, 1'b1);
    cycle();
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL ne_not_taken: got %b want 0", br_taken); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ne_no_bubble: got %b want 1", in_ready); end
    drive(1'b1, 16'h0005, 4'd0, 1'b0, kBR_Z, 16'h2222, 1'b0, 1'b1);
    cycle();
    idle();
    checks++; if (br_taken !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL z_not_taken: got taken=%b flush=%b want 0", br_taken, flush); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL z_no_bubble: got %b want 1", in_ready); end
    checks++; if (flag_z !== 1'b0 || flag_eq !== 1'b1) begin errors++; $display("FAIL nt_flags: got z=%b eq=%b want 0 1", flag_z, flag_eq); end
    checks++; if (retired !== r0 + 16'd2) begin errors++; $display("FAIL nt_retired: got %0d want %0d", retired, r0 + 16'd2); end
  endtask

  task automatic test_steady();
    wb_ready = 1'b0;
    drive(1'b1, 16'h0100, 4'd1, 1'b1, kBR_NONE, 16'h0, 1'b0, 1'b0);
    cycle();
    wb_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 16'h0101 + 16'(i), 4'(i + 2), 1'b1, kBR_NONE, 16'h0, 1'b0, 1'b0);
      checks++; if (wb_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL steady_count[%0d]: got v=%b r=%b want 1 1", i, wb_valid, in_ready); end
      checks++; if (wb_data !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL steady_order[%0d]: got %h want %h", i, wb_data, 16'h0100 + 16'(i)); end
      cycle();
    end
    idle();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h0114) begin errors++; $display("FAIL steady_last: got v=%b d=%h want 1 0114", wb_valid, wb_data); end
    cycle();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL steady_empty: got %b want 0", wb_valid); end
  endtask

  task automatic test_random();
    br_kind_e k;
    for (int i = 0; i < 400; i++) begin
      k = br_kind_e'($urandom_range(0, 3));
      drive(($urandom % 4) != 0, 16'($urandom), 4'($urandom), 1'($urandom),
            k, 16'($urandom), 1'($urandom), 1'($urandom));
      wb_ready = ($urandom % 10) < 7;
      checks++; if (in_ready !== ((q.size() < 2) && !m_br)) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, in_ready, (q.size() < 2) && !m_br); end
      cycle();
      checks++; if (wb_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_wb_valid[%0d]: got %b want %b", i, wb_valid, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if ({wb_addr, wb_data} !== q[0]) begin errors++; $display("FAIL rnd_head[%0d]: got %h want %h", i, {wb_addr, wb_data}, q[0]); end
      end
      checks++; if (br_taken !== m_br || flush !== m_br) begin errors++; $display("FAIL rnd_branch[%0d]: got taken=%b flush=%b want %b", i, br_taken, flush, m_br); end
      if (m_br) begin
        checks++; if (br_pc !== m_pc) begin errors++; $display("FAIL rnd_br_pc[%0d]: got %h want %h", i, br_pc, m_pc); end
      end
      checks++; if (flag_z !== m_z || flag_eq !== m_eq) begin errors++; $display("FAIL rnd_flags[%0d]: got %b%b want %b%b", i, flag_z, flag_eq, m_z, m_eq); end
      checks++; if (retired !== 16'(m_ret)) begin errors++; $display("FAIL rnd_retired[%0d]: got %0d want %0d", i, retired, m_ret); end
    end
    idle();
    wb_ready = 1'b1;
    repeat (3) cycle();
  endtask

  task automatic test_retired_wrap();
    reset_n = 1'b0;
    #1 model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    wb_ready = 1'b1;
    drive(1'b1, 16'h0, 4'h0, 1'b0, kBR_NONE, 16'h0, 1'b0, 1'b0);
    repeat (65535) cycle();
    checks++; if (retired !== 16'hFFFF) begin errors++; $display("FAIL wrap_max: got %h want FFFF", retired); end
    drive(1'b1, 16'h0005, 4'd2, 1'b1, kBR_NONE, 16'h0, 1'b0, 1'b0);
    cycle();
    idle();
    checks++; if (retired !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", retired); end
    cycle();
  endtask

  task automatic test_async_reset();
    wb_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 4'd1, 1'b1, kBR_NONE, 16'h0, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'hBBBB, 4'd2, 1'b1, kBR_Z, 16'h00C0, 1'b1, 1'b0); cycle();
    idle();
    checks++; if (wb_valid !== 1'b1 || br_taken !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL arst_setup: got v=%b t=%b r=%b want 1 1 0", wb_valid, br_taken, in_ready); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0 || wb_data !== 16'h0 || wb_addr !== 4'h0) begin errors++; $display("FAIL arst_fifo: got v=%b d=%h a=%h want 0", wb_valid, wb_data, wb_addr); end
    checks++; if (br_taken !== 1'b0 || flush !== 1'b0 || br_pc !== 16'h0) begin errors++; $display("FAIL arst_branch: got t=%b f=%b pc=%h want 0", br_taken, flush, br_pc); end
    checks++; if (flag_z !== 1'b0 || flag_eq !== 1'b0 || retired !== 16'h0) begin errors++; $display("FAIL arst_state: got z=%b eq=%b ret=%h want 0", flag_z, flag_eq, retired); end
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    checks++; if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL arst_release: got r=%b v=%b want 1 0", in_ready, wb_valid); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_drain();
    test_branch_taken();
    test_branch_not_taken();
    test_steady();
    test_random();
    test_retired_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_retire_stage.md
# alu_retire_stage

Registered stage directly downstream of the ALU. Captures each ALU result with its ZERO/EQUAL flags and the instruction's destination and branch fields. Resolves conditional branches, buffers register-file writes in a 2-entry FIFO, and presents them to the register file over a valid/ready handshake. Also keeps architectural flag registers and a retired-instruction counter.

## Interface
- DEPTH, 2: write-buffer entries; the design is verified for 2 only.
- DW, 16: datapath width, equal to the ALU width.
- AW, 4: register-file address width.
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET_N  in  1  reset, asynchronous and active-low.
- IN_VALID  in  1  upstream offers one instruction this cycle.
- IN_READY  out  1  stage accepts the offered instruction this cycle.
- ALU_OUT  in  DW  ALU result.
- ALU_ZERO  in  1  ALU ZERO flag.
- ALU_EQUAL  in  1  ALU EQUAL flag.
- DEST  in  AW  destination register.
- WE  in  1  instruction writes DEST.
- BR_KIND  in  2  branch type, br_kind_e.
- BR_TARGET  in  DW  branch target PC.
- WB_VALID  out  1  FIFO head is valid.
- WB_READY  in  1  register file consumes the FIFO head.
- WB_DATA  out  DW  FIFO head data.
- WB_ADDR  out  AW  FIFO head address.
- BR_TAKEN  out  1  one-cycle pulse: a branch was taken.
- BR_PC  out  DW  target PC; meaningful while BR_TAKEN=1.
- FLUSH  out  1  one-cycle pulse, coincident with BR_TAKEN.
- FLAG_Z  out  1  architectural zero flag.
- FLAG_EQ  out  1  architectural equal flag.
- RETIRED  out  16  count of accepted instructions.

## Operation
- Accept condition: IN_VALID & IN_READY.
- IN_READY = (count < DEPTH) & ~FLUSH. Both terms are registered state, so IN_READY has no combinational path from IN_VALID or WB_READY.
- On accept:
  - If WE=1, push {DEST, ALU_OUT} into the FIFO.
  - If WE=0, push nothing.
  - Always update FLAG_Z to ALU_ZERO and FLAG_EQ to ALU_EQUAL.
  - Always increment RETIRED, modulo 2^16 (wraps 16'hFFFF to 0).
- Branch resolution, evaluated on accept:
  - kBR_NONE: never taken.
  - kBR_EQ: taken iff ALU_EQUAL.
  - kBR_NE: taken iff ~ALU_EQUAL.
  - kBR_Z: taken iff ALU_ZERO.
- When a branch is taken:
  - Next cycle, BR_TAKEN=1, FLUSH=1 and BR_PC=BR_TAKEN target, each for exactly one cycle.
  - IN_READY=0 during that cycle, so no input is accepted.
- Pop: occurs when WB_VALID & WB_READY. WB_VALID = (count != 0). WB_DATA and WB_ADDR come from the head register, never from the inputs.
- Push and pop in the same cycle:
  - Count is unchanged.
  - Order is preserved: the new entry goes behind the remaining ones.
  - Legal only while count < DEPTH, which IN_READY already enforces.
- Full FIFO (count=DEPTH): IN_READY=0; pops still proceed.
- Empty FIFO: WB_VALID=0; WB_READY is ignored.
- A taken branch with WE=1 still writes its result.

## Timing
- Reset (asserted asynchronously, released synchronously to CLK):
  - count=0, WB_VALID=0, WB_DATA=0, WB_ADDR=0.
  - BR_TAKEN=0, FLUSH=0, BR_PC=0.
  - FLAG_Z=0, FLAG_EQ=0, RETIRED=0.
  - FIFO contents are cleared.
  - IN_READY=1 from the first cycle after release.
- Reset mid-operation: buffered writes, pending FLUSH, flags and counter are all discarded immediately, with no wait for a clock edge.
- Latency:
  - Accept to WB_VALID: 1 cycle when the FIFO was empty.
  - Accept to BR_TAKEN: 1 cycle.
  - Accept to flag and RETIRED visibility: 1 cycle.
- Throughput: one instruction per cycle while WB_READY=1. Each taken branch costs one bubble.

## Structure
- Add to package definitions:
  - typedef enum logic [1:0] br_kind_e {kBR_NONE, kBR_EQ, kBR_NE, kBR_Z}.
  - localparam WB_DEPTH = 2.
- Sub-module wb_fifo holds the circular buffer:
  - Parameters DEPTH and width.
  - Ports push, pop, din, dout, count.
  - Same asynchronous active-low reset.
- The top level holds the branch, flag and counter logic.

## Test plan
- Reset release, then accept ALU_OUT=16'h1234, DEST=3, WE=1 → next cycle WB_VALID=1, WB_DATA=16'h1234, WB_ADDR=3, RETIRED=1.
- WB_READY=0, then offer 3 writes (values 1, 2, 3) → first two accepted, IN_READY=0 on the third. Raise WB_READY → drained in order 1, 2, 3.
- BR_KIND=kBR_EQ, ALU_EQUAL=1, BR_TARGET=16'h0040 → next cycle BR_TAKEN=1, FLUSH=1, BR_PC=16'h0040, IN_READY=0. Instruction held on IN_VALID in that cycle is not accepted and is taken the cycle after.
- kBR_NE with ALU_EQUAL=1, and kBR_Z with ALU_ZERO=0 → BR_TAKEN stays 0 and no bubble occurs.
- Steady push+pop with count=1 for 20 cycles → count stays 1, data order preserved. Separately preload RETIRED to 16'hFFFF and accept one instruction → RETIRED wraps to 0.
- Assert RESET_N=0 mid-cycle with 2 entries buffered and FLUSH pending → all outputs go to their reset values before the next CLK edge.
